// File: rtl/cm_pkg.sv
// Shared types and defaults for the serial conv/MAC sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cm_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int LEN_W     = 6;
    // Cycles between the last read address and a settled PE result:
    // one for buffer data return, one for the PE accumulator register.
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD,
        FIN
    } state_e;

endpackage

// File: rtl/cm_addr_gen.sv
// Element/output counters and activation/weight address generation.
// Latency: addresses are a combinational view of the registered counters.
// Backpressure: counters only move on step_k_i / next_o_i from the sequencer FSM.
module cm_addr_gen
    import cm_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int LW = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          step_k_i,
    input  logic          next_o_i,
    input  logic [LW-1:0] len_i,
    input  logic [LW-1:0] num_i,
    input  logic [LW-1:0] stride_i,
    output logic [AW-1:0] a_addr_o,
    output logic [AW-1:0] b_addr_o,
    output logic          first_k_o,
    output logic          last_k_o,
    output logic          last_o_o
);

    logic [LW-1:0] k_q, k_d;
    logic [LW-1:0] o_q, o_d;
    logic [AW-1:0] base_q, base_d;

    // Next-state for the counters: a new job zeroes everything, a new output
    // restarts k and advances the activation base by the stride.
    always_comb begin
        k_d    = k_q;
        o_d    = o_q;
        base_d = base_q;
        if (clear_i) begin
            k_d    = '0;
            o_d    = '0;
            base_d = '0;
        end else if (next_o_i) begin
            k_d    = '0;
            o_d    = o_q + LW'(1);
            base_d = base_q + AW'(stride_i);
        end else if (step_k_i) begin
            k_d    = k_q + LW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            o_q    <= '0;
            base_q <= '0;
        end else begin
            k_q    <= k_d;
            o_q    <= o_d;
            base_q <= base_d;
        end
    end

    // Address arithmetic wraps mod 2^AW by construction.
    assign a_addr_o  = base_q + AW'(k_q);
    assign b_addr_o  = AW'(k_q);
    assign first_k_o = (k_q == '0);
    assign last_k_o  = (k_q == len_i - LW'(1));
    assign last_o_o  = (o_q == num_i - LW'(1));

endmodule

// File: rtl/cm_serial_seq.sv
// Sequencer driving buffer reads and a serial PE to compute cfg_num dot products.
// Latency: first address 1 cycle after start, each result valid cfg_len+3 cycles later.
// Backpressure: result is held in HOLD until res_ready; the pipeline stalls meanwhile.
module cm_serial_seq
    import cm_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int LEN_W_P  = LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W_P-1:0]  cfg_len,
    input  logic [LEN_W_P-1:0]  cfg_num,
    input  logic [LEN_W_P-1:0]  cfg_stride,
    output logic [ADDR_W_P-1:0] a_addr,
    output logic [ADDR_W_P-1:0] b_addr,
    output logic                rd_en,
    input  logic [DATA_W_P-1:0] a_rdata,
    input  logic [DATA_W_P-1:0] b_rdata,
    output logic [DATA_W_P-1:0] pe_a,
    output logic [DATA_W_P-1:0] pe_b,
    output logic                pe_mux_reset,
    input  logic [DATA_W_P-1:0] pe_out,
    output logic [DATA_W_P-1:0] res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                done
);

    state_e               state_q, state_d;
    logic [1:0]           drain_q, drain_d;
    logic [LEN_W_P-1:0]   len_q, num_q, stride_q;
    logic [DATA_W_P-1:0]  res_data_q, res_data_d;
    logic                 res_valid_q, res_valid_d;
    logic                 d_vld_q, first_q;
    logic                 accept, next_o, first_k, last_k, last_o;

    assign accept = (state_q == IDLE) && start;

    cm_addr_gen #(
        .AW (ADDR_W_P),
        .LW (LEN_W_P)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .step_k_i  (rd_en),
        .next_o_i  (next_o),
        .len_i     (len_q),
        .num_i     (num_q),
        .stride_i  (stride_q),
        .a_addr_o  (a_addr),
        .b_addr_o  (b_addr),
        .first_k_o (first_k),
        .last_k_o  (last_k),
        .last_o_o  (last_o)
    );

    // Next-state, drain counting and result handshake for the job FSM.
    always_comb begin
        state_d     = state_q;
        drain_d     = '0;
        next_o      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_len == '0 || cfg_num == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_k) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_CYC - 1)) begin
                    res_data_d  = pe_out;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    next_o      = !last_o;
                    state_d     = last_o ? FIN : RUN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, drain counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Job configuration is frozen at start acceptance so mid-job changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            num_q    <= '0;
            stride_q <= '0;
        end else if (accept) begin
            len_q    <= cfg_len;
            num_q    <= cfg_num;
            stride_q <= cfg_stride;
        end
    end

    // Align PE controls with the buffer data, which returns one cycle after rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vld_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            d_vld_q <= rd_en;
            first_q <= rd_en && first_k;
        end
    end

    assign rd_en        = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign pe_a         = d_vld_q ? a_rdata : '0;
    assign pe_b         = d_vld_q ? b_rdata : '0;
    assign pe_mux_reset = d_vld_q && first_q;
    assign res_data     = res_data_q;
    assign res_valid    = res_valid_q;

endmodule
